ocp_cmd_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one OCP master command/response channel between two AXI-side requesters (slave-port 1 and slave-port 2 of the interconnect). It issues single-beat read and write commands with a port-encoded MTagID and tracks up to 4 outstanding commands per port. It routes each OCP response back to its requester, restoring the original 4-bit AXI ID. It sits between the interconnect's AXI address/data capture logic and the `ocp_if` master pins.

---
 rtl/ocp_cmd_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_ocp_cmd_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ocp_cmd_arbiter.sv
// Two-port round-robin arbiter sharing one OCP master command/response channel.
// Commands carry MTagID = {port, slot}; in-order responses restore the AXI ID from a per-port table.
module ocp_cmd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_p0,
    output logic          req_ready_p0,
    input  logic          req_write_p0,
    input  logic [3:0]    req_id_p0,
    input  logic [AW-1:0] req_addr_p0,
    input  logic [DW-1:0] req_data_p0,
    input  logic          req_valid_p1,
    output logic          req_ready_p1,
    input  logic          req_write_p1,
    input  logic [3:0]    req_id_p1,
    input  logic [AW-1:0] req_addr_p1,
    input  logic [DW-1:0] req_data_p1,
    output logic [2:0]    MCmd,
    output logic [AW-1:0] MAddr,
    output logic [DW-1:0] MData,
    output logic          MDataValid,
    output logic [2:0]    MTagID,
    input  logic          SCmdAccept,
    input  logic [1:0]    SResp,
    input  logic [DW-1:0] SData,
    input  logic [2:0]    STagID,
    output logic          MRespAccept,
    output logic          rsp_valid_p0,
    input  logic          rsp_ready_p0,
    output logic [3:0]    rsp_id_p0,
    output logic [DW-1:0] rsp_data_p0,
    output logic          rsp_err_p0,
    output logic          rsp_valid_p1,
    input  logic          rsp_ready_p1,
    output logic [3:0]    rsp_id_p1,
    output logic [DW-1:0] rsp_data_p1,
    output logic          rsp_err_p1,
    output logic          tag_err
);
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;
    localparam logic [2:0] MAX_OUT   = 3'd4;

    logic [2:0]    mcmd_q, mcmd_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mdata_q, mdata_d;
    logic          mdv_q, mdv_d;
    logic [2:0]    mtag_q, mtag_d;
    logic          last_grant_q, last_grant_d;
    logic          tag_err_q, tag_err_d;
    logic [2:0]    count_q  [2];
    logic [2:0]    count_d  [2];
    logic [1:0]    alloc_q  [2];
    logic [1:0]    alloc_d  [2];
    logic [1:0]    free_q   [2];
    logic [1:0]    free_d   [2];
    logic [3:0]    id_tab_q [2][4];
    logic [3:0]    id_tab_d [2][4];

    logic          req_valid_s [2];
    logic          req_write_s [2];
    logic [3:0]    req_id_s    [2];
    logic [AW-1:0] req_addr_s  [2];
    logic [DW-1:0] req_data_s  [2];
    logic          rsp_ready_s [2];
    logic          elig_s      [2];
    logic          issue_s     [2];
    logic          rsp_valid_s [2];
    logic          retire_s    [2];
    logic          load_ok_s, gnt_valid_s, gnt_port_s, accept_s;
    logic          rsp_present_s, rsp_port_s, rsp_match_s;

    assign req_valid_s[0] = req_valid_p0;
    assign req_valid_s[1] = req_valid_p1;
    assign req_write_s[0] = req_write_p0;
    assign req_write_s[1] = req_write_p1;
    assign req_id_s[0]    = req_id_p0;
    assign req_id_s[1]    = req_id_p1;
    assign req_addr_s[0]  = req_addr_p0;
    assign req_addr_s[1]  = req_addr_p1;
    assign req_data_s[0]  = req_data_p0;
    assign req_data_s[1]  = req_data_p1;
    assign rsp_ready_s[0] = rsp_ready_p0;
    assign rsp_ready_s[1] = rsp_ready_p1;

    // Eligibility and round-robin grant; eligibility sees only the registered count.
    always_comb begin
        elig_s[0]   = req_valid_s[0] && (count_q[0] != MAX_OUT);
        elig_s[1]   = req_valid_s[1] && (count_q[1] != MAX_OUT);
        load_ok_s   = (mcmd_q == CMD_IDLE) || SCmdAccept;
        gnt_valid_s = 1'b0;
        gnt_port_s  = 1'b0;
        if (elig_s[0] && elig_s[1]) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = ~last_grant_q;
        end else if (elig_s[0]) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b0;
        end else if (elig_s[1]) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = 1'b0;
        end
        accept_s   = gnt_valid_s && load_ok_s && !rst;
        issue_s[0] = accept_s && !gnt_port_s;
        issue_s[1] = accept_s && gnt_port_s;
    end

    assign req_ready_p0 = issue_s[0];
    assign req_ready_p1 = issue_s[1];

    // Response routing: a response is valid only for the oldest outstanding slot of its port.
    always_comb begin
        rsp_present_s  = (SResp != RESP_NULL);
        rsp_port_s     = STagID[2];
        rsp_match_s    = rsp_present_s && (STagID[1:0] == free_q[rsp_port_s])
                         && (count_q[rsp_port_s] != 3'd0);
        rsp_valid_s[0] = rsp_match_s && !rsp_port_s;
        rsp_valid_s[1] = rsp_match_s && rsp_port_s;
        retire_s[0]    = rsp_valid_s[0] && rsp_ready_s[0];
        retire_s[1]    = rsp_valid_s[1] && rsp_ready_s[1];
        if (rsp_match_s) begin
            MRespAccept = rsp_ready_s[rsp_port_s];
        end else begin
            MRespAccept = rsp_present_s;
        end
        tag_err_d = tag_err_q || (rsp_present_s && !rsp_match_s);
    end

    assign rsp_valid_p0 = rsp_valid_s[0];
    assign rsp_valid_p1 = rsp_valid_s[1];
    assign rsp_id_p0    = rsp_valid_s[0] ? id_tab_q[0][free_q[0]] : 4'd0;
    assign rsp_id_p1    = rsp_valid_s[1] ? id_tab_q[1][free_q[1]] : 4'd0;
    assign rsp_data_p0  = rsp_valid_s[0] ? SData : {DW{1'b0}};
    assign rsp_data_p1  = rsp_valid_s[1] ? SData : {DW{1'b0}};
    assign rsp_err_p0   = rsp_valid_s[0] && (SResp == RESP_ERR);
    assign rsp_err_p1   = rsp_valid_s[1] && (SResp == RESP_ERR);

    // Command register: load on grant, clear when the slave takes it with nothing new, else hold.
    always_comb begin
        mcmd_d       = mcmd_q;
        maddr_d      = maddr_q;
        mdata_d      = mdata_q;
        mdv_d        = mdv_q;
        mtag_d       = mtag_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            mcmd_d       = req_write_s[gnt_port_s] ? CMD_WR : CMD_RD;
            maddr_d      = req_addr_s[gnt_port_s];
            mdata_d      = req_write_s[gnt_port_s] ? req_data_s[gnt_port_s] : {DW{1'b0}};
            mdv_d        = req_write_s[gnt_port_s];
            mtag_d       = {gnt_port_s, alloc_q[gnt_port_s]};
            last_grant_d = gnt_port_s;
        end else if (SCmdAccept) begin
            mcmd_d  = CMD_IDLE;
            maddr_d = {AW{1'b0}};
            mdata_d = {DW{1'b0}};
            mdv_d   = 1'b0;
            mtag_d  = 3'd0;
        end else begin
            mcmd_d = mcmd_q;
        end
    end

    // Per-port ID table, pointers and outstanding count; issue and retire in one cycle cancel.
    always_comb begin
        count_d  = count_q;
        alloc_d  = alloc_q;
        free_d   = free_q;
        id_tab_d = id_tab_q;
        for (int p = 0; p < 2; p++) begin
            if (issue_s[p]) begin
                id_tab_d[p][alloc_q[p]] = req_id_s[p];
                alloc_d[p]              = alloc_q[p] + 2'd1;
            end else begin
                alloc_d[p] = alloc_q[p];
            end
            if (retire_s[p]) begin
                free_d[p] = free_q[p] + 2'd1;
            end else begin
                free_d[p] = free_q[p];
            end
            count_d[p] = count_q[p] + {2'b00, issue_s[p]} - {2'b00, retire_s[p]};
        end
    end

    // State registers; reset abandons any in-flight command and forgets outstanding tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcmd_q       <= CMD_IDLE;
            maddr_q      <= {AW{1'b0}};
            mdata_q      <= {DW{1'b0}};
            mdv_q        <= 1'b0;
            mtag_q       <= 3'd0;
            last_grant_q <= 1'b1;
            tag_err_q    <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                count_q[p] <= 3'd0;
                alloc_q[p] <= 2'd0;
                free_q[p]  <= 2'd0;
                for (int i = 0; i < 4; i++) begin
                    id_tab_q[p][i] <= 4'd0;
                end
            end
        end else begin
            mcmd_q       <= mcmd_d;
            maddr_q      <= maddr_d;
            mdata_q      <= mdata_d;
            mdv_q        <= mdv_d;
            mtag_q       <= mtag_d;
            last_grant_q <= last_grant_d;
            tag_err_q    <= tag_err_d;
            count_q      <= count_d;
            alloc_q      <= alloc_d;
            free_q       <= free_d;
            id_tab_q     <= id_tab_d;
        end
    end

    assign MCmd       = mcmd_q;
    assign MAddr      = maddr_q;
    assign MData      = mdata_q;
    assign MDataValid = mdv_q;
    assign MTagID     = mtag_q;
    assign tag_err    = tag_err_q;

endmodule

// File: tb/tb_ocp_cmd_arbiter.sv
// Randomized bench for ocp_cmd_arbiter: a sequence-number reference model plus an in-order OCP slave.
module tb_ocp_cmd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_p0, req_ready_p0, req_write_p0;
    logic [3:0]    req_id_p0;
    logic [AW-1:0] req_addr_p0;
    logic [DW-1:0] req_data_p0;
    logic          req_valid_p1, req_ready_p1, req_write_p1;
    logic [3:0]    req_id_p1;
    logic [AW-1:0] req_addr_p1;
    logic [DW-1:0] req_data_p1;
    logic [2:0]    MCmd, MTagID, STagID;
    logic [AW-1:0] MAddr;
    logic [DW-1:0] MData, SData;
    logic          MDataValid, SCmdAccept, MRespAccept;
    logic [1:0]    SResp;
    logic          rsp_valid_p0, rsp_ready_p0, rsp_err_p0;
    logic          rsp_valid_p1, rsp_ready_p1, rsp_err_p1;
    logic [3:0]    rsp_id_p0, rsp_id_p1;
    logic [DW-1:0] rsp_data_p0, rsp_data_p1;
    logic          tag_err;

    always #5 clk = ~clk;

    ocp_cmd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_p0(req_valid_p0), .req_ready_p0(req_ready_p0), .req_write_p0(req_write_p0),
        .req_id_p0(req_id_p0), .req_addr_p0(req_addr_p0), .req_data_p0(req_data_p0),
        .req_valid_p1(req_valid_p1), .req_ready_p1(req_ready_p1), .req_write_p1(req_write_p1),
        .req_id_p1(req_id_p1), .req_addr_p1(req_addr_p1), .req_data_p1(req_data_p1),
        .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MDataValid(MDataValid), .MTagID(MTagID),
        .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData), .STagID(STagID),
        .MRespAccept(MRespAccept),
        .rsp_valid_p0(rsp_valid_p0), .rsp_ready_p0(rsp_ready_p0), .rsp_id_p0(rsp_id_p0),
        .rsp_data_p0(rsp_data_p0), .rsp_err_p0(rsp_err_p0),
        .rsp_valid_p1(rsp_valid_p1), .rsp_ready_p1(rsp_ready_p1), .rsp_id_p1(rsp_id_p1),
        .rsp_data_p1(rsp_data_p1), .rsp_err_p1(rsp_err_p1),
        .tag_err(tag_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the n-th command issued on a port (from 0) uses slot n mod 4,
    // responses come back in issue order, and outstanding = issued - retired.
    int            issued [2];
    int            retired[2];
    int            slave_acc[2];
    logic [3:0]    idq0[$];
    logic [3:0]    idq1[$];
    int            m_last;
    logic [2:0]    m_cmd, m_tag;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_dv, m_terr, m_fresh;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            issued[p] = 0; retired[p] = 0; slave_acc[p] = 0;
        end
        idq0.delete();
        idq1.delete();
        m_last = 1; m_cmd = 3'd0; m_tag = 3'd0; m_addr = '0; m_data = '0;
        m_dv = 1'b0; m_terr = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic step(input bit do_rst, input int p_req, input int p_acc,
                        input int p_rsp, input int p_bad);
        int   p, g;
        bit   el0, el1, load_ok, acc, bad, rv0, rv1, wr_g;
        logic mra;
        @(negedge clk);
        rst          = do_rst;
        req_valid_p0 = ($urandom_range(99) < p_req);
        req_valid_p1 = ($urandom_range(99) < p_req);
        req_write_p0 = 1'($urandom_range(1));
        req_write_p1 = 1'($urandom_range(1));
        req_id_p0    = 4'($urandom_range(15));
        req_id_p1    = 4'($urandom_range(15));
        req_addr_p0  = $urandom;
        req_addr_p1  = $urandom;
        req_data_p0  = $urandom;
        req_data_p1  = $urandom;
        SCmdAccept   = ($urandom_range(99) < p_acc);
        rsp_ready_p0 = ($urandom_range(99) < 80);
        rsp_ready_p1 = ($urandom_range(99) < 80);
        SResp = 2'd0; STagID = 3'd0; SData = $urandom;
        if (!do_rst && ($urandom_range(99) < p_rsp)) begin
            p = $urandom_range(1);
            if (slave_acc[p] == retired[p]) p = 1 - p;
            if (slave_acc[p] > retired[p]) begin
                SResp  = ($urandom_range(3) == 0) ? 2'd3 : 2'd1;
                STagID = {1'(p), 2'(retired[p])};
            end
        end
        if (!do_rst && ($urandom_range(99) < p_bad)) begin
            p = $urandom_range(1);
            SResp  = 2'd1;
            STagID = {1'(p), 2'(retired[p] + 1)};
        end
        #2;
        // Expected command-side behaviour
        load_ok = (m_cmd == 3'd0) || SCmdAccept;
        el0 = req_valid_p0 && (issued[0] - retired[0] < 4);
        el1 = req_valid_p1 && (issued[1] - retired[1] < 4);
        if (el0 && el1)  g = 1 - m_last;
        else if (el0)    g = 0;
        else if (el1)    g = 1;
        else             g = -1;
        acc = (g >= 0) && load_ok && !do_rst;
        chk("req_ready_p0", 64'(req_ready_p0), 64'(acc && g == 0));
        chk("req_ready_p1", 64'(req_ready_p1), 64'(acc && g == 1));
        chk("MCmd", 64'(MCmd), 64'(m_cmd));
        chk("MDataValid", 64'(MDataValid), 64'(m_dv));
        if (m_cmd != 3'd0 || m_fresh) begin
            chk("MAddr", 64'(MAddr), 64'(m_addr));
            chk("MTagID", 64'(MTagID), 64'(m_tag));
        end
        if (m_cmd == 3'd1 || m_fresh) chk("MData", 64'(MData), 64'(m_data));
        // Expected response-side behaviour
        rv0 = 1'b0; rv1 = 1'b0; mra = 1'b0; bad = 1'b0;
        if (SResp != 2'd0) begin
            p = int'(STagID[2]);
            if (issued[p] > retired[p] && STagID[1:0] == 2'(retired[p])) begin
                if (p == 0) begin rv0 = 1'b1; mra = rsp_ready_p0; end
                else        begin rv1 = 1'b1; mra = rsp_ready_p1; end
            end else begin
                mra = 1'b1;
                bad = 1'b1;
            end
        end
        chk("rsp_valid_p0", 64'(rsp_valid_p0), 64'(rv0));
        chk("rsp_valid_p1", 64'(rsp_valid_p1), 64'(rv1));
        chk("MRespAccept", 64'(MRespAccept), 64'(mra));
        chk("rsp_id_p0", 64'(rsp_id_p0), rv0 ? 64'(idq0[0]) : 64'd0);
        chk("rsp_id_p1", 64'(rsp_id_p1), rv1 ? 64'(idq1[0]) : 64'd0);
        chk("rsp_data_p0", 64'(rsp_data_p0), rv0 ? 64'(SData) : 64'd0);
        chk("rsp_data_p1", 64'(rsp_data_p1), rv1 ? 64'(SData) : 64'd0);
        chk("rsp_err_p0", 64'(rsp_err_p0), 64'(rv0 && SResp == 2'd3));
        chk("rsp_err_p1", 64'(rsp_err_p1), 64'(rv1 && SResp == 2'd3));
        chk("tag_err", 64'(tag_err), 64'(m_terr));
        // Advance the model across the coming clock edge
        if (do_rst) begin
            model_reset();
        end else begin
            if (m_cmd != 3'd0 && SCmdAccept) slave_acc[int'(m_tag[2])]++;
            if (rv0 && rsp_ready_p0) begin retired[0]++; void'(idq0.pop_front()); end
            if (rv1 && rsp_ready_p1) begin retired[1]++; void'(idq1.pop_front()); end
            if (bad) m_terr = 1'b1;
            if (acc) begin
                wr_g = (g == 0) ? req_write_p0 : req_write_p1;
                if (g == 0) idq0.push_back(req_id_p0);
                else        idq1.push_back(req_id_p1);
                m_tag   = {1'(g), 2'(issued[g])};
                issued[g]++;
                m_last  = g;
                m_cmd   = wr_g ? 3'd1 : 3'd2;
                m_addr  = (g == 0) ? req_addr_p0 : req_addr_p1;
                m_data  = wr_g ? ((g == 0) ? req_data_p0 : req_data_p1) : '0;
                m_dv    = wr_g;
                m_fresh = 1'b0;
            end else if (SCmdAccept) begin
                m_cmd = 3'd0;
                m_dv  = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_p0 = 1'b0; req_write_p0 = 1'b0; req_id_p0 = 4'd0; req_addr_p0 = '0; req_data_p0 = '0;
        req_valid_p1 = 1'b0; req_write_p1 = 1'b0; req_id_p1 = 4'd0; req_addr_p1 = '0; req_data_p1 = '0;
        SCmdAccept = 1'b0; SResp = 2'd0; SData = '0; STagID = 3'd0;
        rsp_ready_p0 = 1'b0; rsp_ready_p1 = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        repeat (2) step(1'b1, 60, 50, 0, 0);
        repeat (300) step(1'b0, 70, 70, 50, 0);   // mixed traffic
        repeat (200) step(1'b0, 95, 100, 10, 0);  // contention and outstanding limit
        repeat (200) step(1'b0, 80, 30, 60, 0);   // command backpressure
        step(1'b1, 80, 50, 0, 0);                 // reset mid-operation
        step(1'b0, 0, 100, 0, 100);               // stale response after reset
        repeat (300) step(1'b0, 70, 70, 50, 3);   // mixed traffic with stray tags
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
